// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI register bridge: command codes, FSM states,
// sticky status layout and small helpers used by the sequencer.
package spi_reg_bridge_pkg;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    // Byte pushed to the host when a read access times out
    localparam logic [7:0] READ_TIMEOUT_FILL = 8'hFF;

    // Bit positions of the sticky flags inside the STATUS byte
    localparam int STAT_ABORT   = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_BAD_CMD = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WBUS,
        ST_RBUS,
        ST_RPUSH,
        ST_SPUSH
    } state_t;

    typedef struct packed {
        logic bad_cmd;
        logic timeout;
        logic abort;
    } status_t;

    // LEN byte of 0 encodes a full 256-access burst
    function automatic logic [8:0] burst_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

    // Pack the sticky flags into the byte returned by the STATUS command
    function automatic logic [7:0] status_byte(input status_t s);
        logic [7:0] b;
        b               = '0;
        b[STAT_ABORT]   = s.abort;
        b[STAT_TIMEOUT] = s.timeout;
        b[STAT_BAD_CMD] = s.bad_cmd;
        return b;
    endfunction

endpackage

// File: rtl/spi_reg_bridge.sv
// Command sequencer between the SPI slave RX/TX byte FIFOs and the on-chip
// register bus. Parses CMD,ADDR,LEN[,DATA..] frames, runs auto-incrementing
// burst writes/reads and returns read data or the sticky status byte on TX.
module spi_reg_bridge #(
    parameter int ADDR_W      = 8,
    parameter int BUS_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              frame_abort,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              busy
);
    import spi_reg_bridge_pkg::*;

    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       is_read;
    logic [8:0] burst_cnt;
    logic [7:0] tmo_cnt;
    status_t    status;
    logic       abort_pending;

    logic       rx_open;
    logic       rx_fire;
    logic       tmo_expired;
    logic       bus_done;
    logic       abort_seen;
    logic       last_access;

    // An abort pulse closes the RX side in the same cycle so a byte that
    // arrives together with the abort is left in the FIFO.
    assign rx_open     = !rst && !frame_abort;
    assign rx_fire     = rx_valid && rx_ready;
    assign tmo_expired = (tmo_cnt == TMO_LAST);
    assign bus_done    = ((state == ST_WBUS) || (state == ST_RBUS)) && (bus_ack || tmo_expired);
    assign abort_seen  = abort_pending || frame_abort;
    assign last_access = (burst_cnt == 9'd1);
    assign busy        = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/request outputs, all driven from the current state
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        bus_we     = 1'b0;
        bus_re     = 1'b0;
        case (state)
            ST_IDLE: begin
                rx_ready = rx_open;
                if (rx_valid && rx_open) begin
                    if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        state_next = ST_ADDR;
                    end else if (rx_data == CMD_STATUS) begin
                        state_next = ST_SPUSH;
                    end
                end
            end
            ST_ADDR: begin
                rx_ready = rx_open;
                if (frame_abort) begin
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                rx_ready = rx_open;
                if (frame_abort) begin
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    state_next = is_read ? ST_RBUS : ST_WDATA;
                end
            end
            ST_WDATA: begin
                rx_ready = rx_open;
                if (frame_abort) begin
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    state_next = ST_WBUS;
                end
            end
            ST_WBUS: begin
                bus_we = 1'b1;
                if (bus_done) begin
                    state_next = (abort_seen || last_access) ? ST_IDLE : ST_WDATA;
                end
            end
            ST_RBUS: begin
                bus_re = 1'b1;
                if (bus_done) begin
                    state_next = abort_seen ? ST_IDLE : ST_RPUSH;
                end
            end
            ST_RPUSH: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = (abort_seen || (burst_cnt == 9'd0)) ? ST_IDLE : ST_RBUS;
                end
            end
            ST_SPUSH: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame fields, burst/timeout counters, TX byte and sticky status bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            is_read       <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            tx_data       <= '0;
            burst_cnt     <= '0;
            tmo_cnt       <= '0;
            status        <= '0;
            abort_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        case (rx_data)
                            CMD_NOP:    ;
                            CMD_WRITE:  is_read <= 1'b0;
                            CMD_READ:   is_read <= 1'b1;
                            CMD_STATUS: tx_data <= status_byte(status);
                            default:    status.bad_cmd <= 1'b1;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (frame_abort) begin
                        status.abort <= 1'b1;
                    end else if (rx_fire) begin
                        bus_addr <= ADDR_W'(rx_data);
                    end
                end
                ST_LEN: begin
                    if (frame_abort) begin
                        status.abort <= 1'b1;
                    end else if (rx_fire) begin
                        burst_cnt <= burst_count(rx_data);
                        tmo_cnt   <= '0;
                    end
                end
                ST_WDATA: begin
                    if (frame_abort) begin
                        status.abort <= 1'b1;
                    end else if (rx_fire) begin
                        bus_wdata <= rx_data;
                    end
                end
                ST_WBUS, ST_RBUS: begin
                    if (frame_abort) begin
                        abort_pending <= 1'b1;
                    end
                    if (bus_done) begin
                        bus_addr  <= bus_addr + ADDR_W'(1);
                        burst_cnt <= burst_cnt - 9'd1;
                        tmo_cnt   <= '0;
                        if (!bus_ack) begin
                            status.timeout <= 1'b1;
                        end
                        if ((state == ST_RBUS) && !abort_seen) begin
                            tx_data <= bus_ack ? bus_rdata : READ_TIMEOUT_FILL;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RPUSH: begin
                    if (frame_abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                ST_SPUSH: begin
                    if (tx_ready) begin
                        status <= '0;
                    end
                end
                default: ;
            endcase
            if (state_next == ST_IDLE) begin
                abort_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed frames plus random bursts,
// checked against a frame-level model of register memory, TX bytes and status.
module tb_spi_reg_bridge;

    localparam int ADDR_W      = 8;
    localparam int BUS_TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              frame_abort;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [7:0]        bus_rdata;
    logic              bus_ack;
    logic              busy;

    int errors = 0;
    int checks = 0;

    spi_reg_bridge #(.ADDR_W(ADDR_W), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_abort(frame_abort),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register slave contents and the model's view of what they should hold
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];

    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];
    logic [7:0]  tx_log[$];
    int          pulse_log[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];

    int   ack_delay = 0;
    int   req_cycles = 0;
    int   pulse_len = 0;
    int   both_seen = 0;
    int   tx_stall = 0;
    bit   tx_rand = 1'b0;
    int   hold_violations = 0;
    bit   hold_active = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit   st_bad = 1'b0;
    bit   st_tmo = 1'b0;
    bit   st_abort = 1'b0;

    // Bus slave: acks after ack_delay request cycles (never when negative), logs completed accesses
    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (bus_we && bus_re) both_seen++;
        if (bus_we || bus_re) begin
            pulse_len++;
            if (ack_delay >= 0 && req_cycles == ack_delay) begin
                bus_ack = 1'b1;
                if (bus_we) begin
                    wr_log.push_back({bus_addr, bus_wdata});
                    mem[bus_addr] = bus_wdata;
                end else begin
                    rd_log.push_back(bus_addr);
                    bus_rdata = mem[bus_addr];
                end
                req_cycles = 0;
            end else begin
                bus_rdata = 8'($urandom);
                req_cycles++;
            end
        end else begin
            if (pulse_len > 0) pulse_log.push_back(pulse_len);
            pulse_len  = 0;
            req_cycles = 0;
        end
    end

    // TX FIFO: stalls, random or always-ready acceptance; records bytes and hold violations
    always @(negedge clk) begin
        if (tx_stall > 0) begin
            tx_ready = 1'b0;
            tx_stall--;
        end else if (tx_rand) begin
            tx_ready = ($urandom_range(0, 2) != 0);
        end else begin
            tx_ready = 1'b1;
        end
        if (hold_active && (!tx_valid || tx_data !== hold_data)) hold_violations++;
        hold_active = 1'b0;
        if (tx_valid) begin
            if (tx_ready) begin
                tx_log.push_back(tx_data);
            end else begin
                hold_active = 1'b1;
                hold_data   = tx_data;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        while (!rx_ready && n < 300) begin
            step();
            n++;
        end
        if (!rx_ready) check_output("rx_accept", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        step();
        while (busy && n < 3000) begin
            step();
            n++;
        end
        check_output({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); tx_log.delete(); pulse_log.delete();
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    endtask

    task automatic compare_logs(input string tag);
        check_output({tag, "_wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check_output({tag, "_wr"}, 32'(wr_log[i]), 32'(exp_wr[i]));
        check_output({tag, "_rd_count"}, 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check_output({tag, "_rd_addr"}, 32'(rd_log[i]), 32'(exp_rd[i]));
        check_output({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check_output({tag, "_tx"}, 32'(tx_log[i]), 32'(exp_tx[i]));
        clear_logs();
    endtask

    function automatic int burst_of(input logic [7:0] len);
        return (len == 8'd0) ? 256 : int'(len);
    endfunction

    task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input string tag);
        logic [7:0] a;
        logic [7:0] d;
        clear_logs();
        send_byte(8'h01);
        send_byte(addr);
        send_byte(len);
        for (int i = 0; i < burst_of(len); i++) begin
            a = addr + 8'(i);
            d = 8'($urandom);
            exp_wr.push_back({a, d});
            ref_mem[a] = d;
            send_byte(d);
            if (i == 0) check_output({tag, "_we_latency"}, 32'(bus_we), 32'd1);
        end
        wait_idle(tag);
        compare_logs(tag);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] len, input string tag);
        logic [7:0] a;
        clear_logs();
        for (int i = 0; i < burst_of(len); i++) begin
            a = addr + 8'(i);
            if (ack_delay >= 0) begin
                exp_rd.push_back(a);
                exp_tx.push_back(ref_mem[a]);
            end else begin
                exp_tx.push_back(8'hFF);
                st_tmo = 1'b1;
            end
        end
        send_byte(8'h02);
        send_byte(addr);
        send_byte(len);
        wait_idle(tag);
        compare_logs(tag);
    endtask

    task automatic do_status(input string tag);
        clear_logs();
        exp_tx.push_back({5'b0, st_bad, st_tmo, st_abort});
        st_bad = 1'b0; st_tmo = 1'b0; st_abort = 1'b0;
        send_byte(8'h03);
        wait_idle(tag);
        compare_logs(tag);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] l;
        int n;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_abort = 1'b0;
        bus_ack = 1'b0; bus_rdata = 8'h00; tx_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) step();
        $display("[TB] reset checks");
        check_output("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_output("rst_outputs", 32'({tx_valid, tx_data, bus_we, bus_re, bus_addr, bus_wdata, busy}), 32'd0);
        rst = 1'b0;
        step();
        check_output("idle_rx_ready", 32'(rx_ready), 32'd1);
        do_status("rst_status");

        $display("[TB] directed write burst");
        ack_delay = 2;
        clear_logs();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA);
        check_output("wr_we_latency", 32'(bus_we), 32'd1);
        send_byte(8'hBB);
        exp_wr.push_back(16'h10AA); exp_wr.push_back(16'h11BB);
        ref_mem[8'h10] = 8'hAA; ref_mem[8'h11] = 8'hBB;
        wait_idle("wr_dir");
        compare_logs("wr_dir");

        $display("[TB] directed read with address wrap");
        ack_delay = 1;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
        ref_mem[8'hFE] = 8'h11; ref_mem[8'hFF] = 8'h22; ref_mem[8'h00] = 8'h33;
        do_read(8'hFE, 8'd3, "rd_wrap");

        $display("[TB] ack to tx_valid latency");
        ack_delay = 3;
        clear_logs();
        exp_rd.push_back(8'h30); exp_tx.push_back(ref_mem[8'h30]);
        send_byte(8'h02); send_byte(8'h30); send_byte(8'h01);
        n = 0;
        while (!bus_ack && n < 50) begin
            step();
            n++;
        end
        check_output("lat_ack_seen", 32'(bus_ack), 32'd1);
        step();
        check_output("lat_tx_valid", 32'(tx_valid), 32'd1);
        check_output("lat_tx_data", 32'(tx_data), 32'(ref_mem[8'h30]));
        wait_idle("lat");
        compare_logs("lat");

        $display("[TB] read timeout and status");
        ack_delay = -1;
        do_read(8'h20, 8'd1, "rd_tmo");
        step();
        ack_delay = 0;
        clear_logs();
        send_byte(8'h02); send_byte(8'h20); send_byte(8'h01);
        ack_delay = -1;
        pulse_log.delete();
        tx_log.delete(); rd_log.delete();
        clear_logs();
        send_byte(8'h02); send_byte(8'h20); send_byte(8'h01);
        wait_idle("tmo_len");
        check_output("tmo_pulse_len", 32'((pulse_log.size() > 0) ? pulse_log[pulse_log.size() - 1] : 0), 32'(BUS_TIMEOUT));
        check_output("tmo_fill", 32'((tx_log.size() > 0) ? tx_log[0] : 8'h00), 32'hFF);
        clear_logs();
        do_status("status_tmo");
        do_status("status_clear");

        $display("[TB] abort during write burst");
        ack_delay = 1;
        clear_logs();
        send_byte(8'h01); send_byte(8'h40); send_byte(8'h04); send_byte(8'h55);
        exp_wr.push_back(16'h4055); ref_mem[8'h40] = 8'h55;
        n = 0;
        while (wr_log.size() < 1 && n < 50) begin
            step();
            n++;
        end
        step();
        frame_abort = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
        #1;
        check_output("abort_rx_ready", 32'(rx_ready), 32'd0);
        step();
        frame_abort = 1'b0; rx_valid = 1'b0;
        check_output("abort_idle", 32'(busy), 32'd0);
        st_abort = 1'b1;
        repeat (4) step();
        compare_logs("abort_wr");
        do_status("status_abort");

        $display("[TB] bad command and NOP");
        clear_logs();
        send_byte(8'h7E);
        step();
        check_output("bad_cmd_idle", 32'(busy), 32'd0);
        st_bad = 1'b1;
        send_byte(8'h00);
        step();
        check_output("nop_idle", 32'(busy), 32'd0);
        do_status("status_bad");
        ack_delay = 0;
        do_read(8'h00, 8'd1, "rd_after_bad");

        $display("[TB] TX backpressure");
        ack_delay = 1;
        clear_logs();
        exp_rd.push_back(8'h50); exp_rd.push_back(8'h51);
        exp_tx.push_back(ref_mem[8'h50]); exp_tx.push_back(ref_mem[8'h51]);
        tx_stall = 20;
        send_byte(8'h02); send_byte(8'h50); send_byte(8'h02);
        repeat (10) step();
        check_output("stall_tx_valid", 32'(tx_valid), 32'd1);
        check_output("stall_tx_data", 32'(tx_data), 32'(ref_mem[8'h50]));
        check_output("stall_one_read", 32'(rd_log.size()), 32'd1);
        check_output("stall_no_re", 32'(bus_re), 32'd0);
        wait_idle("stall");
        compare_logs("stall");

        $display("[TB] full 256 read burst");
        ack_delay = 0;
        do_read(8'hF0, 8'd0, "rd_256");

        $display("[TB] random bursts");
        tx_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 8'($urandom);
            l = 8'($urandom_range(1, 5));
            ack_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) do_write(a, l, "rnd_wr");
            else do_read(a, l, "rnd_rd");
        end
        tx_rand = 1'b0;
        do_status("status_rnd");

        $display("[TB] reset mid-read");
        send_byte(8'h7E);
        ack_delay = -1;
        send_byte(8'h02); send_byte(8'h60); send_byte(8'h02);
        repeat (3) step();
        check_output("mid_re_high", 32'(bus_re), 32'd1);
        rst = 1'b1;
        step();
        check_output("mid_re_low", 32'(bus_re), 32'd0);
        check_output("mid_busy", 32'(busy), 32'd0);
        check_output("mid_addr", 32'(bus_addr), 32'd0);
        rst = 1'b0;
        st_bad = 1'b0; st_tmo = 1'b0; st_abort = 1'b0;
        step();
        clear_logs();
        ack_delay = 0;
        do_status("status_after_rst");

        check_output("we_re_exclusive", 32'(both_seen), 32'd0);
        check_output("tx_hold", 32'(hold_violations), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
